// File: rtl/counter_button_ctrl.sv
// counter_button_ctrl: synchronize, debounce and arbitrate up/down/load buttons into counter strobes.
// Optional hold-to-repeat FSM is built when COUNTER_BTN_AUTOREPEAT_EN is defined.
module counter_button_ctrl #(
  parameter int DB_CYCLES  = 16,
  parameter int RPT_DELAY  = 256,
  parameter int RPT_PERIOD = 32,
  parameter int TMR_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  output logic       count_en,
  output logic       count_up,
  output logic       do_load,
  output logic [2:0] btn_level
);
  logic [2:0] s1, s2, lvl_d, press;
  logic [TMR_W-1:0] db_tmr [3];
  logic up_hit, dn_hit, strobe, strobe_dir;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      lvl_d <= '0;
      btn_level <= '0;
      for (int i = 0; i < 3; i++) db_tmr[i] <= '0;
    end else begin
      s1 <= {btn_load, btn_down, btn_up};
      s2 <= s1;
      lvl_d <= btn_level;
      for (int i = 0; i < 3; i++)
        if (s2[i] == btn_level[i]) db_tmr[i] <= '0;
        else if (db_tmr[i] == TMR_W'(DB_CYCLES - 1)) begin
          db_tmr[i] <= '0;
          btn_level[i] <= ~btn_level[i];
        end else db_tmr[i] <= db_tmr[i] + 1'b1;
    end
  // a direction press is ignored while load is pressed or the opposite level is high
  assign press  = btn_level & ~lvl_d;
  assign up_hit = press[0] & ~press[2] & ~btn_level[1];
  assign dn_hit = press[1] & ~press[2] & ~btn_level[0];
`ifdef COUNTER_BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  state_t state, state_n;
  logic [TMR_W-1:0] rpt_tmr, rpt_tmr_n;
  logic rpt_dir, rpt_dir_n, rpt_fire, quit;
  assign quit = (rpt_dir ? ~btn_level[0] | btn_level[1] : ~btn_level[1] | btn_level[0]) | press[2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rpt_tmr <= '0;
      rpt_dir <= 1'b1;
    end else begin
      state <= state_n;
      rpt_tmr <= rpt_tmr_n;
      rpt_dir <= rpt_dir_n;
    end
  always_comb begin
    state_n = state;
    rpt_tmr_n = rpt_tmr + 1'b1;
    rpt_dir_n = rpt_dir;
    rpt_fire = 1'b0;
    if (up_hit | dn_hit) begin
      state_n = DELAY;
      rpt_tmr_n = '0;
      rpt_dir_n = up_hit;
    end else if (state != IDLE && quit) begin
      state_n = IDLE;
      rpt_tmr_n = '0;
    end else if ((state == DELAY && rpt_tmr == TMR_W'(RPT_DELAY - 1)) ||
                 (state == REPEAT && rpt_tmr == TMR_W'(RPT_PERIOD - 1))) begin
      state_n = REPEAT;
      rpt_tmr_n = '0;
      rpt_fire = 1'b1;
    end else if (state == IDLE) rpt_tmr_n = '0;
  end
  assign strobe     = up_hit | dn_hit | rpt_fire;
  assign strobe_dir = (up_hit | dn_hit) ? up_hit : rpt_dir;
`else
  assign strobe     = up_hit | dn_hit;
  assign strobe_dir = up_hit;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_en <= 1'b0;
      do_load <= 1'b0;
      count_up <= 1'b1;
    end else begin
      count_en <= strobe;
      do_load <= press[2];
      if (strobe) count_up <= strobe_dir;
    end
endmodule

// File: tb/tb_counter_button_ctrl.sv
// tb_counter_button_ctrl: directed stimulus with a queued scoreboard checked by a concurrent monitor.
module tb_counter_button_ctrl;
  logic clk = 1'b0, rst = 1'b1, btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
  logic count_en, count_up, do_load;
  logic [2:0] btn_level;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {int kind; int at;} ev_t;
  ev_t exp_q[$];
  counter_button_ctrl #(.DB_CYCLES(4), .RPT_DELAY(20), .RPT_PERIOD(5), .TMR_W(16)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
    .count_en(count_en), .count_up(count_up), .do_load(do_load), .btn_level(btn_level));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  // kind: 0 = count up, 1 = count down, 2 = load
  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at = at;
    exp_q.push_back(e);
  endtask
  task automatic chk_reset_outs();
    chk("rst_count_en", int'(count_en), 0);
    chk("rst_do_load", int'(do_load), 0);
    chk("rst_count_up", int'(count_up), 1);
    chk("rst_btn_level", int'(btn_level), 0);
  endtask
  initial begin
    int c, r, t;
    fork
      forever begin
        ev_t e;
        @(negedge clk);
        if (count_en || do_load) begin
          chk("exclusive", int'(count_en && do_load), 0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected strobe at cycle %0d: count_en=%0b do_load=%0b count_up=%0b",
                     cyc, count_en, do_load, count_up);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_kind", do_load ? 2 : (count_up ? 0 : 1), e.kind);
            chk("strobe_cycle", cyc, e.at);
          end
        end
      end
    join_none
    // reset held with buttons toggling
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {btn_load, btn_down, btn_up} = 3'($urandom_range(0, 7));
      chk_reset_outs();
    end
    @(negedge clk);
    {btn_load, btn_down, btn_up} = 3'b000;
    rst = 1'b0;
    cycles(10);
    chk("idle_level", int'(btn_level), 0);
    // clean up press
    c = cyc;
    btn_up = 1'b1;
    push(0, c + 7);
    cycles(6);
    chk("up_level", int'(btn_level), 3'b001);
    cycles(4);
    btn_up = 1'b0;
    cycles(12);
    chk("up_released", int'(btn_level), 0);
    // clean down press
    c = cyc;
    btn_down = 1'b1;
    push(1, c + 7);
    cycles(6);
    chk("down_level", int'(btn_level), 3'b010);
    cycles(4);
    btn_down = 1'b0;
    cycles(12);
    chk("down_held_dir", int'(count_up), 0);
    // bounce shorter than the debounce window
    for (int w = 1; w <= 3; w++) begin
      btn_up = 1'b1;
      cycles(w);
      btn_up = 1'b0;
      cycles(1);
      chk("bounce_level", int'(btn_level[0]), 0);
    end
    cycles(8);
    chk("bounce_after", int'(btn_level[0]), 0);
    // load and up together: load wins
    c = cyc;
    btn_load = 1'b1;
    btn_up = 1'b1;
    push(2, c + 7);
    cycles(8);
    btn_load = 1'b0;
    btn_up = 1'b0;
    cycles(12);
    // up and down together: nothing
    btn_up = 1'b1;
    btn_down = 1'b1;
    cycles(8);
    chk("both_level", int'(btn_level), 3'b011);
    btn_up = 1'b0;
    btn_down = 1'b0;
    cycles(12);
    chk("both_dir_kept", int'(count_up), 0);
    // reset while down is held
    c = cyc;
    btn_down = 1'b1;
    push(1, c + 7);
    cycles(9);
    rst = 1'b1;
    cycles(1);
    chk_reset_outs();
    cycles(1);
    chk_reset_outs();
    rst = 1'b0;
    r = cyc;
    push(1, r + 7);
    cycles(10);
    btn_down = 1'b0;
    cycles(12);
    // long up hold, down raised mid-repeat
    c = cyc;
    t = c + 7;
    btn_up = 1'b1;
    push(0, t);
`ifdef COUNTER_BTN_AUTOREPEAT_EN
    for (int k = 20; k <= 45; k += 5) push(0, t + k);
`endif
    cycles(48);
    btn_down = 1'b1;
    cycles(20);
    chk("hold_both_level", int'(btn_level), 3'b011);
    btn_up = 1'b0;
    btn_down = 1'b0;
    cycles(15);
    chk("final_dir", int'(count_up), 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/counter_button_ctrl.md
Name: counter_button_ctrl

Overview:
Upstream control stage for the 8-bit up/down load counter. Takes three raw, bouncy push-buttons (up, down, load) and produces the counter's control strobes: single-cycle count_en with direction, and a single-cycle do_load.
- Each button gets a 2-flop synchronizer and a stability debouncer.
- Rising edges of the debounced levels are arbitrated.
- A hold-to-repeat FSM is optional (see Optional Feature).

Parameters:
DB_CYCLES, 16, consecutive stable synchronized cycles required to change a debounced level (>=2)
RPT_DELAY, 256, cycles from press pulse to first repeat pulse (>=2)
RPT_PERIOD, 32, cycles between subsequent repeat pulses (>=2)
TMR_W, 16, width of the debounce and repeat timers; must hold max(DB_CYCLES, RPT_DELAY, RPT_PERIOD)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
btn_up  in  1  raw up button, asynchronous to clk
btn_down  in  1  raw down button, asynchronous to clk
btn_load  in  1  raw load button, asynchronous to clk
count_en  out  1  one-cycle count strobe
count_up  out  1  direction of the most recent count strobe (1=up, 0=down); held between strobes
do_load  out  1  one-cycle load strobe
btn_level  out  3  debounced levels {load, down, up}

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). No other clock or reset.
- Reset values:
  - count_en=0, do_load=0, count_up=1, btn_level=3'b000.
  - Sync flops, debounce timers and repeat timer cleared; FSM=IDLE.
- Synchronizer: two flops per button; the second flop is the sync value.
- Debouncer (per button):
  - The timer increments while sync != debounced level and clears when they are equal.
  - When the timer reaches DB_CYCLES-1 with sync still different, the level flips next edge and the timer clears.
  - Glitches shorter than DB_CYCLES cycles never change the level.
- Latency: raw held high from edge N gives debounced level high at edge N+DB_CYCLES+1 and the strobe high in the cycle after edge N+DB_CYCLES+2. All outputs are registered.
- Press events are debounced rising edges only; releases generate nothing.
- Arbitration, per cycle, on press events:
  - load press: do_load=1 for one cycle; any up/down press in the same cycle is discarded, not deferred.
  - up press only: count_en=1, count_up=1.
  - down press only: count_en=1, count_up=0.
  - up and down press in the same cycle: no strobe; count_up unchanged.
  - A press arriving while the other direction's level is high: no strobe.
- count_en and do_load are never high in the same cycle. Neither is ever high for two consecutive cycles from a single press.
- Reset mid-hold: all levels return to 0. A button still held after rst deasserts is re-debounced and yields one new press strobe.

Optional Feature:
Macro: COUNTER_BTN_AUTOREPEAT_EN
- Defined: adds repeat FSM with states IDLE, DELAY, REPEAT.
  - IDLE->DELAY on an up/down strobe; timer cleared; the held direction is latched.
  - DELAY: after RPT_DELAY cycles from the strobe, emit count_en with the latched direction, then ->REPEAT.
  - REPEAT: emit a strobe every RPT_PERIOD cycles.
  - Exit to IDLE, no strobe, when any of these occurs: the latched button's level falls, the opposite button's level rises, or the load level rises.
  - Load never repeats.
- Undefined: no FSM or repeat timer logic. Exactly one strobe per press.

Test Plan:
Use DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5 for all scenarios.
1. Reset: hold rst with all buttons toggling -> count_en=0, do_load=0, count_up=1, btn_level=0 throughout.
2. Clean up press held 10 cycles from edge N -> one count_en pulse, count_up=1, strobe in the cycle after edge N+6. Repeat for down -> count_up=0.
3. Bounce: btn_up pulses 1,2,3 cycles wide with 1-cycle gaps, then stays low -> no strobe; btn_level[0] stays 0.
4. Simultaneous: btn_load and btn_up rise on the same edge and are held 8 cycles -> exactly one do_load pulse, no count_en. Up and down rise together -> no strobes.
5. Reset mid-hold: btn_down held, rst pulsed for 2 cycles after its strobe -> outputs cleared; a second down strobe 6 cycles after rst deasserts.
6. COUNTER_BTN_AUTOREPEAT_EN defined, btn_up held 50 cycles after its strobe at cycle T -> strobes at T, T+20, T+25, T+30, …, T+45. Raising btn_down mid-repeat stops the strobes. With the macro undefined -> only the strobe at T.
